// File: rtl/obuf_frame_reader.sv
// obuf_frame_reader: scans the RGB565 output frame buffer and streams pixels over valid/ready
module obuf_frame_reader #(
   parameter int WIDTH  = 480,
   parameter int HEIGHT = 272,
   parameter int ADDR_W = 17
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic              iStart,
   input  logic              iContinuous,
   input  logic              iStop,
   input  logic [15:0]       iBufData,
   input  logic              iReady,
   output logic              oBufEn,
   output logic [ADDR_W-1:0] oRdAddr,
   output logic [15:0]       oPixel,
   output logic [23:0]       oRgb888,
   output logic              oValid,
   output logic              oSof,
   output logic              oEol,
   output logic              oEof,
   output logic              oBusy,
   output logic              oDone
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH * HEIGHT - 1);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t            state_q;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CW-1:0]     col_q, col_d;
   logic [RW-1:0]     row_q, row_d;
   logic              cont_q, stop_q;
   logic              b_vld_q, b_sof_q, b_eol_q, b_eof_q;
   logic              o_vld_q, o_sof_q, o_eol_q, o_eof_q, done_q;
   logic [15:0]       pixel_q;
   logic [23:0]       rgb_q;
   logic              advance, run, last_addr, eol_addr, fin;
   assign advance   = !o_vld_q | iReady;
   assign run       = (state_q == RUN);
   assign last_addr = (addr_q == LAST);
   assign eol_addr  = (col_q == CW'(WIDTH - 1));
   assign fin       = (state_q == DRAIN) & o_vld_q & iReady & o_eof_q;
   assign oBufEn    = advance & (run | b_vld_q);
   assign oRdAddr   = addr_q;
   assign oPixel    = pixel_q;
   assign oRgb888   = rgb_q;
   assign oValid    = o_vld_q;
   assign oSof      = o_sof_q;
   assign oEol      = o_eol_q;
   assign oEof      = o_eof_q;
   assign oBusy     = (state_q != IDLE);
   assign oDone     = done_q;
   // next raster position: address wraps at end of frame, col at end of line, row at end of frame
   always_comb begin
      addr_d = last_addr ? '0 : addr_q + 1'b1;
      col_d  = eol_addr ? '0 : col_q + 1'b1;
      row_d  = eol_addr ? ((row_q == RW'(HEIGHT - 1)) ? '0 : row_q + 1'b1) : row_q;
   end
   // scan control: address stage counters, frame looping and the sticky stop request
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         col_q   <= '0;
         row_q   <= '0;
         cont_q  <= 1'b0;
         stop_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= fin;
         case (state_q)
            IDLE: if (iStart) begin
               state_q <= RUN;
               addr_q  <= '0;
               col_q   <= '0;
               row_q   <= '0;
               cont_q  <= iContinuous;
               stop_q  <= 1'b0;
            end
            RUN: begin
               if (iStop) stop_q <= 1'b1;
               if (advance) begin
                  addr_q <= addr_d;
                  col_q  <= col_d;
                  row_q  <= row_d;
                  if (last_addr && !(cont_q && !stop_q && !iStop)) state_q <= DRAIN;
               end
            end
            DRAIN: if (fin) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
   // buffer and output stages advance together; buffer-stage tags move exactly with the SRAM register
   always_ff @(posedge iClk) begin
      if (iRst) begin
         b_vld_q <= 1'b0;
         b_sof_q <= 1'b0;
         b_eol_q <= 1'b0;
         b_eof_q <= 1'b0;
         o_vld_q <= 1'b0;
         o_sof_q <= 1'b0;
         o_eol_q <= 1'b0;
         o_eof_q <= 1'b0;
         pixel_q <= '0;
         rgb_q   <= '0;
      end else begin
         if (oBufEn) begin
            b_vld_q <= run;
            b_sof_q <= (addr_q == '0);
            b_eol_q <= eol_addr;
            b_eof_q <= last_addr;
         end
         if (advance) begin
            o_vld_q <= b_vld_q;
            o_sof_q <= b_sof_q;
            o_eol_q <= b_eol_q;
            o_eof_q <= b_eof_q;
            pixel_q <= iBufData;
            rgb_q   <= {iBufData[15:11], iBufData[15:13], iBufData[10:5], iBufData[10:9],
                        iBufData[4:0], iBufData[4:2]};
         end
      end
   end
endmodule

// File: tb/tb_obuf_frame_reader.sv
// tb_obuf_frame_reader: self-checking bench with a small SRAM model and a pixel-stream reference queue
module tb_obuf_frame_reader;
   localparam int W = 4;
   localparam int H = 2;
   localparam int N = W * H;
   logic        clk = 1'b0;
   logic        iRst = 1'b1, iStart = 1'b0, iContinuous = 1'b0, iStop = 1'b0, iReady = 1'b1;
   logic [15:0] iBufData;
   logic        oBufEn, oValid, oSof, oEol, oEof, oBusy, oDone;
   logic [2:0]  oRdAddr;
   logic [15:0] oPixel;
   logic [23:0] oRgb888;
   obuf_frame_reader #(.WIDTH(W), .HEIGHT(H), .ADDR_W(3)) dut (
      .iClk(clk), .iRst(iRst), .iStart(iStart), .iContinuous(iContinuous), .iStop(iStop),
      .iBufData(iBufData), .iReady(iReady), .oBufEn(oBufEn), .oRdAddr(oRdAddr), .oPixel(oPixel),
      .oRgb888(oRgb888), .oValid(oValid), .oSof(oSof), .oEol(oEol), .oEof(oEof), .oBusy(oBusy),
      .oDone(oDone));
   always #5 clk = ~clk;
   // frame buffer: registered read port that holds while its clock enable is low
   logic [15:0] mem [N];
   always @(posedge clk) if (oBufEn) iBufData <= mem[oRdAddr];
   typedef struct {logic [15:0] pix; logic sof, eol, eof, fin;} exp_t;
   exp_t exp_q[$];
   int   checks = 0, errors = 0, hs_cnt = 0, done_cnt = 0;
   bit   mon_en = 1'b0, done_exp = 1'b0, stall_prev = 1'b0;
   logic [49:0] held;
   logic [23:0] cap_rgb [N];
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic logic [23:0] rgb_of(input logic [15:0] p);
      int r, g, b;
      r = (int'(p) >> 11) & 31;
      g = (int'(p) >> 5) & 63;
      b = int'(p) & 31;
      return 24'(((((r << 3) | (r >> 2))) << 16) | ((((g << 2) | (g >> 4))) << 8) | ((b << 3) | (b >> 2)));
   endfunction
   task automatic push_frames(input int n);
      for (int f = 0; f < n; f++)
         for (int i = 0; i < N; i++)
            exp_q.push_back('{mem[i], i == 0, (i % W) == W - 1, i == N - 1, (f == n - 1) && (i == N - 1)});
   endtask
   // monitor: handshakes against the reference queue, stall stability, done timing
   always @(negedge clk) begin
      if (mon_en) begin
         chk("done_pulse", 64'(oDone), 64'(done_exp));
         if (oDone) done_cnt++;
         done_exp = 1'b0;
         if (stall_prev) chk("stall_hold", 64'({oRdAddr, oPixel, oRgb888, oSof, oEol, oEof, oValid}), 64'(held));
         if (oValid && !iReady) begin
            chk("bufen_stall", 64'(oBufEn), 64'd0);
            held = {oRdAddr, oPixel, oRgb888, oSof, oEol, oEof, oValid};
            stall_prev = 1'b1;
         end else stall_prev = 1'b0;
         if (oValid && iReady) begin
            if (exp_q.size() == 0) chk("extra_pixel", 64'(oPixel), 64'hdead);
            else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("pixel", 64'(oPixel), 64'(e.pix));
               chk("rgb888", 64'(oRgb888), 64'(rgb_of(e.pix)));
               chk("flags", 64'({oSof, oEol, oEof}), 64'({e.sof, e.eol, e.eof}));
               cap_rgb[hs_cnt % N] = oRgb888;
               done_exp = e.fin;
               hs_cnt++;
            end
         end
      end else begin
         stall_prev = 1'b0;
         done_exp = 1'b0;
      end
   end
   task automatic start_frame(input bit cont, input int frames);
      push_frames(frames);
      done_cnt = 0;
      hs_cnt = 0;
      iContinuous = cont;
      iStart = 1'b1;
   endtask
   task automatic run(input bit rnd, input int stop_at, input int start_at, input int budget, input int exp_px);
      int  c;
      bit  sent_stop, sent_start;
      c = 0; sent_stop = 0; sent_start = 0;
      while (done_cnt == 0 && c < budget) begin
         @(posedge clk); #1;
         iReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         iStop = 1'b0;
         iStart = 1'b0;
         if (stop_at >= 0 && !sent_stop && hs_cnt >= stop_at) begin iStop = 1'b1; sent_stop = 1; end
         if (start_at >= 0 && !sent_start && hs_cnt >= start_at) begin iStart = 1'b1; sent_start = 1; end
         c++;
      end
      repeat (6) begin @(posedge clk); #1; iReady = 1'b1; iStop = 1'b0; iStart = 1'b0; end
      chk("done_count", 64'(done_cnt), 64'd1);
      chk("pixel_count", 64'(hs_cnt), 64'(exp_px));
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
   endtask
   typedef struct {int start, ready, valid, pix, sof, eol, eof, busy, bufen, done, ca, addr;} vec_t;
   typedef struct {int p, e;} rgb_t;
   vec_t vec [13];
   rgb_t rgb_tab [6];
   bit   found;
   initial begin
      //          st rd vl pix sof eol eof busy en done ca addr
      vec[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vec[1]  = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0};
      vec[2]  = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1};
      vec[3]  = '{0, 1, 1, 0, 1, 0, 0, 1, 1, 0, 1, 2};
      vec[4]  = '{0, 1, 1, 1, 0, 0, 0, 1, 1, 0, 1, 3};
      vec[5]  = '{0, 1, 1, 2, 0, 0, 0, 1, 1, 0, 1, 4};
      vec[6]  = '{0, 1, 1, 3, 0, 1, 0, 1, 1, 0, 1, 5};
      vec[7]  = '{0, 1, 1, 4, 0, 0, 0, 1, 1, 0, 1, 6};
      vec[8]  = '{0, 1, 1, 5, 0, 0, 0, 1, 1, 0, 1, 7};
      vec[9]  = '{0, 1, 1, 6, 0, 0, 0, 1, 1, 0, 0, 0};
      vec[10] = '{0, 1, 1, 7, 0, 1, 1, 1, 0, 0, 0, 0};
      vec[11] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
      vec[12] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      rgb_tab = '{'{32'hF800, 32'hFF0000}, '{32'h07E0, 32'h00FF00}, '{32'h001F, 32'h0000FF},
                  '{32'h8410, 32'h848284}, '{32'hFFFF, 32'hFFFFFF}, '{32'h0000, 32'h000000}};
      for (int i = 0; i < N; i++) mem[i] = 16'(i);
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("reset_outs", 64'({oBufEn, oRdAddr, oPixel, oValid, oSof, oEol, oEof, oBusy, oDone}), 64'd0);
      chk("reset_rgb", 64'(oRgb888), 64'd0);
      @(posedge clk); #1;
      iRst = 1'b0;
      // cycle-exact single frame with iReady held high
      push_frames(1);
      done_cnt = 0; hs_cnt = 0; mon_en = 1'b1;
      for (int k = 0; k < 13; k++) begin
         iStart = vec[k].start[0];
         iReady = vec[k].ready[0];
         @(negedge clk);
         chk("tab_valid", 64'(oValid), 64'(vec[k].valid));
         chk("tab_busy", 64'(oBusy), 64'(vec[k].busy));
         chk("tab_bufen", 64'(oBufEn), 64'(vec[k].bufen));
         chk("tab_done", 64'(oDone), 64'(vec[k].done));
         if (vec[k].valid != 0) chk("tab_pix_flags", 64'({oPixel, oSof, oEol, oEof}),
                                    64'({vec[k].pix[15:0], vec[k].sof[0], vec[k].eol[0], vec[k].eof[0]}));
         if (vec[k].ca != 0) chk("tab_addr", 64'(oRdAddr), 64'(vec[k].addr));
         @(posedge clk); #1;
      end
      chk("tab_pixels", 64'(hs_cnt), 64'd8);
      // random backpressure, single frame
      start_frame(0, 1);
      run(1, -1, -1, 300, 8);
      // colour expansion
      for (int i = 0; i < 6; i++) mem[i] = 16'(rgb_tab[i].p);
      mem[6] = 16'h1234; mem[7] = 16'hABCD;
      start_frame(0, 1);
      run(0, -1, -1, 100, 8);
      for (int i = 0; i < 6; i++) chk("rgb_table", 64'(cap_rgb[i]), 64'(rgb_tab[i].e));
      for (int i = 0; i < N; i++) mem[i] = 16'(i);
      // continuous mode stopped during frame 2
      start_frame(1, 2);
      run(1, 10, -1, 400, 16);
      // start while busy is ignored
      start_frame(0, 1);
      run(0, -1, 3, 100, 8);
      // reset mid-frame under backpressure
      start_frame(0, 1);
      found = 0;
      for (int c = 0; c < 50 && !found; c++) begin
         @(posedge clk); #1;
         iStart = 1'b0; iReady = 1'b1;
         @(negedge clk);
         found = oValid && oPixel == 16'd4;
      end
      chk("reach_px4", 64'(found), 64'd1);
      @(posedge clk); #1;
      chk("px5_present", 64'({oValid, oPixel}), 64'({1'b1, 16'd5}));
      mon_en = 1'b0; iReady = 1'b0; iRst = 1'b1;
      @(posedge clk); #1;
      iRst = 1'b0;
      @(negedge clk);
      chk("midrst_outs", 64'({oBufEn, oRdAddr, oPixel, oValid, oSof, oEol, oEof, oBusy, oDone}), 64'd0);
      chk("midrst_rgb", 64'(oRgb888), 64'd0);
      exp_q.delete();
      @(posedge clk); #1;
      mon_en = 1'b1;
      start_frame(0, 1);
      run(1, -1, -1, 300, 8);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end
endmodule

// File: doc/obuf_frame_reader.md
# obuf_frame_reader

Read-side scan-out engine for the RGB565 output frame buffer (dual-port SRAM, 130560 entries = 480x272, 1-cycle registered read with clock-enable hold). On start it walks read addresses 0..WIDTH*HEIGHT-1 and streams pixels out over a valid/ready interface. It carries start-of-frame, end-of-line and end-of-frame flags, and presents both raw RGB565 and RGB888-expanded data. It sits between the output buffer's read port and the display / host transfer logic, while the CNN write side fills the buffer through the other port.

## Interface
- WIDTH, 480, pixels per line
- HEIGHT, 272, lines per frame
- ADDR_W, 17, read address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT
- iClk  in  1  single clock, rising edge
- iRst  in  1  synchronous, active-high reset
- iStart  in  1  one-cycle start pulse; sampled only in IDLE
- iContinuous  in  1  1 = loop frames until stopped; sampled with iStart
- iStop  in  1  request to end continuous scan at the next frame boundary; sticky until honoured
- iBufData  in  16  buffer read data (buffer oData)
- iReady  in  1  downstream accepts pixel
- oBufEn  out  ADDR_W? no, 1  drives buffer iEnClk; 1 = buffer read register advances
- oRdAddr  out  ADDR_W  buffer iRdAddr
- oPixel  out  16  RGB565 pixel
- oRgb888  out  24  expanded pixel {R5,R5[4:2], G6,G6[5:4], B5,B5[4:2]}
- oValid  out  1  oPixel/oRgb888/flags valid
- oSof, oEol, oEof  out  1 each  qualified by oValid
- oBusy  out  1  state != IDLE
- oDone  out  1  one-cycle pulse after the final pixel of the final frame is accepted

## Operation
- FSM: IDLE, RUN, DRAIN.
  - IDLE: on iStart go to RUN, clear address/col/row counters, latch iContinuous, clear the stop flag.
  - RUN: issue one address per advance cycle. After address WIDTH*HEIGHT-1 is issued:
    - if continuous and no stop pending, wrap to 0 and stay in RUN;
    - otherwise go to DRAIN.
  - DRAIN: no new addresses. When the last pixel handshake (oValid & iReady with oEof) occurs, go to IDLE and pulse oDone.
- Pipeline has three stages, all stalled together:
  - address stage: counter, col, row;
  - buffer stage: SRAM output register, plus registered valid and flags;
  - output stage: oPixel, oRgb888, flags, oValid.
- advance = !oValid | iReady.
- oBufEn = advance & (address stage holds a live address, or the buffer stage holds live data that must move).
  - When advance = 0, oBufEn = 0, so the buffer holds its data. No skid buffer is needed.
- Flags are derived at the address stage and delayed alongside the data:
  - sof = (addr == 0);
  - eol = (col == WIDTH-1);
  - eof = (addr == WIDTH*HEIGHT-1).
- col wraps at WIDTH-1 and increments row; row wraps at HEIGHT-1. All counters are unsigned and exact, with no overflow beyond ADDR_W.
- iStop arriving in RUN sets a sticky flag. The current frame always completes in full; there are no partial frames.
- iStart while oBusy is ignored. iStop in IDLE is ignored.
- This block never writes the buffer. The system guarantees the frame is not rewritten during scan.

## Timing
- Reset (iRst=1 at an edge): state IDLE. oBufEn, oRdAddr, oPixel, oRgb888, oValid, oSof, oEol, oEof, oBusy and oDone are all 0. Counters and stop flag are 0.
- Reset takes priority over every other input, including mid-frame. In-flight pixels are discarded; no oDone.
- iStart sampled at edge 0:
  - oBusy=1 and oBufEn=1 with oRdAddr=0 during cycle 0→1;
  - buffer register loads mem[0] at edge 1;
  - oValid=1 with oPixel=mem[0] and oSof=1 after edge 2.
- With iReady held at 1, throughput is 1 pixel/clock and a frame takes WIDTH*HEIGHT+2 cycles from start.
- When oValid=1 and iReady=0, all outputs hold stable and oRdAddr holds.
- Continuous mode: address WIDTH*HEIGHT-1 is followed directly by 0, with no bubble between frames.
- oDone is high for exactly the cycle after the final handshake edge; oBusy falls on the same edge.
- iStart in that same cycle is accepted, because state is IDLE.

## Test plan
- WIDTH=4, HEIGHT=2, mem[i]=i, iReady=1, single frame → oPixel 0..7 on consecutive cycles, first valid 2 edges after iStart. oSof on pixel 0; oEol on pixels 3 and 7; oEof on pixel 7; oDone 1 cycle later.
- Same setup with iReady toggling pseudo-randomly → identical sequence 0..7 with no loss or duplication; outputs stable while stalled; oBufEn=0 in every stalled cycle.
- mem = {F800, 07E0, 001F, 8410, FFFF, 0000, …} → oRgb888 = FF0000, 00FF00, 0000FF, 848284, FFFFFF, 000000.
- iContinuous=1, iStop pulsed mid-frame 2 → frames 1 and 2 are complete (16 pixels, the second oSof at pixel 8), followed by one oDone and no 17th pixel.
- iRst asserted at pixel 5 under backpressure → next cycle all outputs are 0 and state is IDLE. A new iStart then restarts cleanly from pixel 0.
- iStart pulsed at pixel 3 while busy → ignored; exactly 8 pixels and one oDone.
